dg0045_rom_responder: RTL and testbench

Program-memory responder for the DG0045 4-bit core: the far end of the core's multiplexed instruction-fetch interface. It drives the half-select line, samples the 5-bit multiplexed PC bus twice per scan to assemble the 10-bit fetch address, reads a 1024×8 program store, and presents the instruction byte on the core's ROM input. A valid/ready loader port writes the program store at run time.

---
 rtl/dg0045_pkg.sv | 26 ++
 rtl/dg0045_rom_responder_if.sv | 27 ++
 rtl/dg0045_prog_rom.sv | 22 ++
 rtl/dg0045_rom_responder.sv | 163 ++++++++++++++++
 tb/tb_dg0045_rom_responder.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dg0045_pkg.sv
// Shared types and constants for the DG0045 program-memory responder.
package dg0045_pkg;

  localparam int ROM_AW = 10;
  localparam int ROM_DW = 8;
  localparam int HALF_W = 5;

  // Opcode 8'h00 is a no-op on the core, so it is a harmless reset value.
  localparam logic [ROM_DW-1:0] NOP_OP = 8'h00;

  typedef enum logic [2:0] {
    S_LO_SET,
    S_LO_SMP,
    S_HI_SET,
    S_HI_SMP,
    S_READ,
    S_OUT
  } scan_state_t;

  // The upper half of the PC is selected from the start of the hi settle
  // period until the store read is done; every other state selects the low half.
  function automatic logic mux_for_state(scan_state_t s);
    return (s == S_HI_SET) || (s == S_HI_SMP) || (s == S_READ);
  endfunction

endpackage

// File: rtl/dg0045_rom_responder_if.sv
// Core-facing fetch bus plus the loader write port of the ROM responder.
interface dg0045_rom_responder_if;
  import dg0045_pkg::*;

  logic [HALF_W-1:0] pc_hl;
  logic              pc_mux;
  logic [ROM_DW-1:0] rom_data;
  logic [ROM_AW-1:0] cur_addr;
  logic              fetch_upd;
  logic              prog_valid;
  logic              prog_ready;
  logic [ROM_AW-1:0] prog_addr;
  logic [ROM_DW-1:0] prog_data;

  // Core and loader side.
  modport master (
    output pc_hl, prog_valid, prog_addr, prog_data,
    input  pc_mux, rom_data, cur_addr, fetch_upd, prog_ready
  );

  // Responder side.
  modport slave (
    input  pc_hl, prog_valid, prog_addr, prog_data,
    output pc_mux, rom_data, cur_addr, fetch_upd, prog_ready
  );

endinterface

// File: rtl/dg0045_prog_rom.sv
// Single-port 1024x8 program store with synchronous read (read-before-write).
module dg0045_prog_rom
  import dg0045_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ROM_AW-1:0] addr,
  input  logic [ROM_DW-1:0] wdata,
  output logic [ROM_DW-1:0] rdata
);

  logic [ROM_DW-1:0] mem [0:(1<<ROM_AW)-1];

  // Contents survive reset; only the loader ever changes them.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dg0045_rom_responder.sv
// Far end of the DG0045 multiplexed fetch interface: scans the 5-bit PC bus
// in two halves, reads the program store and presents the instruction byte.
// Optional macro DG0045_PC_DEGLITCH_EN: each half is captured twice and only
// accepted when both captures agree.
module dg0045_rom_responder
  import dg0045_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  dg0045_rom_responder_if.slave   rsp
);

  localparam logic [1:0] SETTLE_LAST = 2'(SETTLE - 1);

  scan_state_t       state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [HALF_W-1:0] lo_q, lo_d;
  logic [HALF_W-1:0] hi_q, hi_d;
`ifdef DG0045_PC_DEGLITCH_EN
  logic [HALF_W-1:0] first_q, first_d;
  logic              phase_q, phase_d;
`endif

  logic              pc_mux_q;
  logic [ROM_DW-1:0] rom_data_q;
  logic [ROM_AW-1:0] cur_addr_q;
  logic              fetch_upd_q;
  logic              prog_ready_q;

  logic [ROM_AW-1:0] fetch_addr;
  logic [ROM_AW-1:0] rom_addr;
  logic [ROM_DW-1:0] rom_rdata;
  logic              prog_we;

  assign fetch_addr = {hi_q, lo_q};
  // Ready is low during S_READ, so a write never steals the scan read.
  assign prog_we    = rsp.prog_valid && prog_ready_q;
  assign rom_addr   = prog_we ? rsp.prog_addr : fetch_addr;

  dg0045_prog_rom u_rom (
    .clk   (clk),
    .we    (prog_we),
    .addr  (rom_addr),
    .wdata (rsp.prog_data),
    .rdata (rom_rdata)
  );

  // Scan state, settle counter and captured PC halves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LO_SET;
      cnt_q   <= 2'd0;
      lo_q    <= '0;
      hi_q    <= '0;
`ifdef DG0045_PC_DEGLITCH_EN
      first_q <= '0;
      phase_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
`ifdef DG0045_PC_DEGLITCH_EN
      first_q <= first_d;
      phase_q <= phase_d;
`endif
    end
  end

  // Next-state logic for the cyclic scan.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
`ifdef DG0045_PC_DEGLITCH_EN
    first_d = first_q;
    phase_d = phase_q;
`endif
    case (state_q)
      S_LO_SET: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = 2'd0;
          state_d = S_LO_SMP;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_LO_SMP: begin
`ifdef DG0045_PC_DEGLITCH_EN
        // Retry with the newer capture until two in a row agree.
        first_d = rsp.pc_hl;
        if (!phase_q) begin
          phase_d = 1'b1;
        end else if (rsp.pc_hl == first_q) begin
          lo_d    = rsp.pc_hl;
          phase_d = 1'b0;
          state_d = S_HI_SET;
        end
`else
        lo_d    = rsp.pc_hl;
        state_d = S_HI_SET;
`endif
      end
      S_HI_SET: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = 2'd0;
          state_d = S_HI_SMP;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_HI_SMP: begin
`ifdef DG0045_PC_DEGLITCH_EN
        first_d = rsp.pc_hl;
        if (!phase_q) begin
          phase_d = 1'b1;
        end else if (rsp.pc_hl == first_q) begin
          hi_d    = rsp.pc_hl;
          phase_d = 1'b0;
          state_d = S_READ;
        end
`else
        hi_d    = rsp.pc_hl;
        state_d = S_READ;
`endif
      end
      S_READ:  state_d = S_OUT;
      S_OUT:   state_d = S_LO_SET;
      default: state_d = S_LO_SET;
    endcase
  end

  // Registered outputs; S_OUT latches the word read during S_READ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_mux_q     <= 1'b0;
      rom_data_q   <= NOP_OP;
      cur_addr_q   <= '0;
      fetch_upd_q  <= 1'b0;
      prog_ready_q <= 1'b0;
    end else begin
      pc_mux_q     <= mux_for_state(state_d);
      prog_ready_q <= (state_d != S_READ);
      fetch_upd_q  <= 1'b0;
      if (state_q == S_OUT) begin
        rom_data_q  <= rom_rdata;
        cur_addr_q  <= fetch_addr;
        fetch_upd_q <= (fetch_addr != cur_addr_q);
      end
    end
  end

  assign rsp.pc_mux     = pc_mux_q;
  assign rsp.rom_data   = rom_data_q;
  assign rsp.cur_addr   = cur_addr_q;
  assign rsp.fetch_upd  = fetch_upd_q;
  assign rsp.prog_ready = prog_ready_q;

endmodule

// File: tb/tb_dg0045_rom_responder.sv
// Scoreboard bench for dg0045_rom_responder: a core model muxes a 10-bit PC
// onto pc_hl, expected fetches are queued by the stimulus and popped by a
// monitor on every fetch_upd pulse.
module tb_dg0045_rom_responder;
  import dg0045_pkg::*;

  localparam int SETTLE = 1;
`ifdef DG0045_PC_DEGLITCH_EN
  localparam int SMP_CLKS = 2;
`else
  localparam int SMP_CLKS = 1;
`endif

  typedef struct packed {
    logic [9:0] addr;
    logic [7:0] data;
  } fetch_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] pc;
  logic       glitch_en;
  logic [4:0] glitch_val;
  int         checks = 0;
  int         failures = 0;
  fetch_t     exp_q[$];

  dg0045_rom_responder_if bus();

  dg0045_rom_responder #(.SETTLE(SETTLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rsp   (bus)
  );

  always #5 clk = ~clk;

  // Core model: drives the half selected by pc_mux, optionally glitched.
  always_comb begin
    bus.pc_hl = glitch_en ? glitch_val : (bus.pc_mux ? pc[9:5] : pc[4:0]);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every fetch_upd pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    fetch_t e;
    if (rst_n && bus.fetch_upd) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_fetch actual addr=%03h data=%02h required no pulse",
                 bus.cur_addr, bus.rom_data);
      end else begin
        e = exp_q.pop_front();
        check("fetch_addr", 32'(bus.cur_addr), 32'(e.addr));
        check("fetch_data", 32'(bus.rom_data), 32'(e.data));
        $display("fetch addr=%03h data=%02h (expected %03h/%02h)",
                 bus.cur_addr, bus.rom_data, e.addr, e.data);
      end
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_pc_mux"},     32'(bus.pc_mux),     32'd0);
    check({tag, "_rom_data"},   32'(bus.rom_data),   32'h00);
    check({tag, "_cur_addr"},   32'(bus.cur_addr),   32'h000);
    check({tag, "_fetch_upd"},  32'(bus.fetch_upd),  32'd0);
    check({tag, "_prog_ready"}, 32'(bus.prog_ready), 32'd0);
  endtask

  // Returns at the negedge where pc_mux has just fallen (state S_OUT).
  task automatic sync_scan_end();
    logic prev;
    bit   done;
    int   n;
    prev = bus.pc_mux;
    done = 0;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      done = prev && !bus.pc_mux;
      prev = bus.pc_mux;
    end
    check("sync_scan_end_found", 32'(done), 32'd1);
  endtask

  // Returns at the negedge where pc_mux has just risen (state S_HI_SET).
  task automatic sync_scan_hi();
    logic prev;
    bit   done;
    int   n;
    prev = bus.pc_mux;
    done = 0;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      done = !prev && bus.pc_mux;
      prev = bus.pc_mux;
    end
    check("sync_scan_hi_found", 32'(done), 32'd1);
  endtask

  task automatic load(input logic [9:0] a, input logic [7:0] d);
    int n;
    bus.prog_valid = 1'b1;
    bus.prog_addr  = a;
    bus.prog_data  = d;
    n = 0;
    while (!bus.prog_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("load_accepted", 32'(bus.prog_ready), 32'd1);
    @(negedge clk);
    bus.prog_valid = 1'b0;
    $display("load addr=%03h data=%02h", a, d);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int n;
    pc = 10'h000;
    glitch_en = 1'b0;
    glitch_val = 5'h00;
    bus.prog_valid = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    rst_n = 1'b0;
    step(3);
    check_reset("rst");
    rst_n = 1'b1;

    load(10'h2A5, 8'hC3);
    load(10'h2AA, 8'h5A);
    load(10'h000, 8'h11);
    load(10'h001, 8'h22);

    // First fetch of a loaded location.
    sync_scan_end();
    pc = 10'h2A5;
    exp_q.push_back({10'h2A5, 8'hC3});
    drain("load_fetch_within_12", 12);

    // Ten scans with a steady PC: no further pulses, outputs steady.
    step(60);
    check("hold_rom_data", 32'(bus.rom_data), 32'hC3);
    check("hold_cur_addr", 32'(bus.cur_addr), 32'h2A5);

    // Sequential PC.
    sync_scan_end();
    pc = 10'h000;
    exp_q.push_back({10'h000, 8'h11});
    drain("seq_fetch_000", 12);
    sync_scan_end();
    pc = 10'h001;
    exp_q.push_back({10'h001, 8'h22});
    drain("seq_fetch_001", 12);

    // Handshake: request raised in S_READ is held off one clock.
    n = 0;
    while (bus.prog_ready && n < 20) begin
      step(1);
      n++;
    end
    bus.prog_valid = 1'b1;
    bus.prog_addr  = 10'h001;
    bus.prog_data  = 8'h33;
    check("hs_ready_low_in_read", 32'(bus.prog_ready), 32'd0);
    step(1);
    check("hs_ready_high_after_read", 32'(bus.prog_ready), 32'd1);
    step(1);
    bus.prog_valid = 1'b0;
    check("hs_rom_data_unchanged", 32'(bus.rom_data), 32'h22);
    step(14);
    check("hs_rom_data_updated", 32'(bus.rom_data), 32'h33);
    check("hs_cur_addr_same", 32'(bus.cur_addr), 32'h001);
    $display("handshake write addr=001 data=33");

    // One-clock glitch on the low half during S_LO_SMP.
    sync_scan_end();
    pc = 10'h2A5;
    step(1 + SETTLE);
    glitch_val = 5'h0A;
    glitch_en  = 1'b1;
    step(1);
    glitch_en  = 1'b0;
`ifdef DG0045_PC_DEGLITCH_EN
    exp_q.push_back({10'h2A5, 8'hC3});
    drain("glitch_rejected", 20);
`else
    exp_q.push_back({10'h2AA, 8'h5A});
    drain("glitch_accepted", 20);
    exp_q.push_back({10'h2A5, 8'hC3});
    drain("glitch_recovered", 20);
`endif

    // Reset during S_HI_SET aborts the scan immediately.
    sync_scan_hi();
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    exp_q.push_back({10'h2A5, 8'hC3});
    step(2);
    rst_n = 1'b1;
    n = 0;
    while (!bus.pc_mux && n < 10) begin
      step(1);
      n++;
    end
    check("first_sample_delay", 32'(n), 32'(SETTLE + SMP_CLKS));
    drain("post_reset_fetch", 16);

    step(20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
